hex_scan: RTL and testbench
===========================

HEX_SCAN -- requirements
Module: hex_scan

Interface
REQ-001 Parameter DIGITS, default 3: number of multiplexed digits, legal range 1..8.
REQ-002 Parameter SYS_CLK_FREQ, default 125000000: clk frequency in Hz.
REQ-003 Parameter REFRESH_RATE, default 100: full-frame refresh rate in Hz.
REQ-004 Parameter BLANK_TICKS, default 0: anti-ghost interval in clk cycles at the start of each digit slot; must be less than TPD.
REQ-005 Parameter SEG_ACTIVE_LOW, default 1: a value of 1 inverts segments.
REQ-006 Parameter EN_ACTIVE_LOW, default 1: a value of 1 inverts segments_enable.
REQ-007 clk  in  1  sole clock; all logic is on its rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 in_value  in  4*DIGITS  hex value; nibble i is digit i; digit 0 is the rightmost digit.
REQ-010 in_dp  in  DIGITS  decimal-point request per digit.
REQ-011 in_valid  in  1  in_value and in_dp are offered.
REQ-012 in_ready  out  1  block can accept an offered value.
REQ-013 segments  out  8  bit 7 is DP; bits 6:0 are segments g..a.
REQ-014 segments_enable  out  DIGITS  one-hot digit enable.
REQ-015 frame_start  out  1  one-cycle pulse at each frame boundary.

Function
REQ-016 TPD is the number of clk cycles per digit slot: floor(SYS_CLK_FREQ/(REFRESH_RATE*DIGITS)), clamped to a minimum of 1.
REQ-017 A prescaler counts 0..TPD-1 and wraps; the digit index advances 0..DIGITS-1 on each wrap, then returns to 0.
REQ-018 A frame boundary is the cycle in which the digit index becomes 0; frame_start is high only in that cycle.
REQ-019 Handshake: a transfer occurs when in_valid and in_ready are both high; the value and DP bits are captured into a pending register; in_ready drops in the following cycle.
REQ-020 On a frame boundary with pending full, the pending register copies to the display register and pending empties; in_ready rises in the next cycle.
REQ-021 If a transfer and a boundary coincide while pending is empty, the new value goes to pending and is displayed from the next frame; a displayed frame never mixes two values.
REQ-022 in_valid while in_ready is low has no effect; the offer is held off and is not dropped silently.
REQ-023 Decode (active-high, gfedcba): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71; DP = display DP bit.
REQ-024 segments and segments_enable are registered, with one cycle of latency from the index/prescaler state.
REQ-025 While prescaler < BLANK_TICKS, all enables are inactive; with BLANK_TICKS=0 an enable is always active.
REQ-026 The polarity parameters are applied at the output registers only.

Reset
REQ-027 During reset: prescaler=0, index=0, display register=0, DP=0, pending empty, frame_start=0, segments all inactive, enables all inactive.
REQ-028 in_ready=1 from the first cycle after reset deasserts.
REQ-029 Digit 0 (showing 0) is driven from the second cycle after reset deasserts.
REQ-030 Reset mid-operation discards pending and display contents with no further output glitch.

Configuration
REQ-031 Macro HEX_SCAN_LZB_EN controls leading-zero blanking.
REQ-032 When HEX_SCAN_LZB_EN is defined: digits above the most significant nonzero nibble show no a..g segments; DP still follows its bit; digit 0 is never blanked.
REQ-033 When HEX_SCAN_LZB_EN is undefined: every digit is decoded, leading zeros included.

Verification (DIGITS=3, SYS_CLK_FREQ=1200, REFRESH_RATE=100 -> TPD=4, polarity=1)
REQ-034 Reset released -> enables cycle 110,101,011 every 4 cycles; segments=C0 (digit "0") throughout; frame_start every 12 cycles.
REQ-035 in_value=12'hA5F accepted mid-frame -> the current frame still shows 000; the next frame shows digit0 F=8E, digit1 5=92, digit2 A=88; in_ready low until that boundary plus one cycle.
REQ-036 Two back-to-back offers 12'h123 then 12'h456 -> the second is held (in_ready=0) until the boundary; frames show 123 then 456; no frame mixes the two values.
REQ-037 in_dp=3'b010 with value 12'h008 and HEX_SCAN_LZB_EN defined -> digit2 segments=FF, digit1=7F (DP only), digit0=80; without the macro -> digit2=C0, digit1=40.
REQ-038 BLANK_TICKS=1 -> each slot has 1 cycle with all enables high (inactive) followed by 3 active cycles.
REQ-039 reset asserted for 1 cycle mid-frame with pending full -> outputs inactive, then the display restarts at digit 0 showing 000; in_ready=1.

Source files
------------

// File: rtl/hex_scan.sv
// hex_scan: multiplexed hexadecimal seven-segment display driver.
// A prescaler and digit index time-share the segment bus across DIGITS
// digits. New values arrive through a valid/ready handshake into a
// pending register and are only shown from a frame boundary, so a frame
// never mixes two values.
// Optional feature: define HEX_SCAN_LZB_EN to blank leading zero digits.
module hex_scan #(
  parameter int DIGITS         = 3,
  parameter int SYS_CLK_FREQ   = 125000000,
  parameter int REFRESH_RATE   = 100,
  parameter int BLANK_TICKS    = 0,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int EN_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   in_value,
  input  logic [DIGITS-1:0]     in_dp,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [7:0]            segments,
  output logic [DIGITS-1:0]     segments_enable,
  output logic                  frame_start
);

  localparam int TPD_RAW = SYS_CLK_FREQ / (REFRESH_RATE * DIGITS);
  localparam int TPD     = (TPD_RAW < 1) ? 1 : TPD_RAW;
  localparam int PW      = (TPD > 1) ? $clog2(TPD) : 1;
  localparam int IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0]     PRESC_LAST = PW'(TPD - 1);
  localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [7:0]        SEG_OFF    = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] EN_OFF     = (EN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [PW-1:0]       presc_q, presc_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] disp_val_q, disp_val_d;
  logic [DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [4*DIGITS-1:0] pend_val_q, pend_val_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                pend_full_q, pend_full_d;
  logic                ready_q, ready_d;
  logic                fs_q, fs_d;
  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   en_q, en_d;
  logic                in_blank;

  // Active-high gfedcba pattern for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_to_seg = 7'h3F;
      4'h1: hex_to_seg = 7'h06;
      4'h2: hex_to_seg = 7'h5B;
      4'h3: hex_to_seg = 7'h4F;
      4'h4: hex_to_seg = 7'h66;
      4'h5: hex_to_seg = 7'h6D;
      4'h6: hex_to_seg = 7'h7D;
      4'h7: hex_to_seg = 7'h07;
      4'h8: hex_to_seg = 7'h7F;
      4'h9: hex_to_seg = 7'h6F;
      4'hA: hex_to_seg = 7'h77;
      4'hB: hex_to_seg = 7'h7C;
      4'hC: hex_to_seg = 7'h39;
      4'hD: hex_to_seg = 7'h5E;
      4'hE: hex_to_seg = 7'h79;
      default: hex_to_seg = 7'h71;
    endcase
  endfunction

  // Anti-ghost window: with no blanking the comparison is dropped entirely.
  generate
    if (BLANK_TICKS == 0) begin : g_no_blank
      assign in_blank = 1'b0;
    end else begin : g_blank
      localparam logic [PW:0] BLANK_W = (PW + 1)'(BLANK_TICKS);
      assign in_blank = ({1'b0, presc_q} < BLANK_W);
    end
  endgenerate

  // Scan timing and the pending/display handoff at frame boundaries.
  always_comb begin
    logic presc_wrap;
    logic frame_wrap;
    presc_wrap  = (presc_q == PRESC_LAST);
    frame_wrap  = presc_wrap && (idx_q == IDX_LAST);
    presc_d     = presc_wrap ? '0 : presc_q + PW'(1);
    idx_d       = idx_q;
    if (presc_wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end
    disp_val_d  = disp_val_q;
    disp_dp_d   = disp_dp_q;
    pend_val_d  = pend_val_q;
    pend_dp_d   = pend_dp_q;
    pend_full_d = pend_full_q;
    if (frame_wrap && pend_full_q) begin
      disp_val_d  = pend_val_q;
      disp_dp_d   = pend_dp_q;
      pend_full_d = 1'b0;
    end else if (in_valid && ready_q) begin
      pend_val_d  = in_value;
      pend_dp_d   = in_dp;
      pend_full_d = 1'b1;
    end
    ready_d = !pend_full_d;
    fs_d    = frame_wrap;
  end

  // Segment and enable patterns for the digit currently being scanned.
  always_comb begin
    logic [3:0] nib;
    logic       dp_bit;
    logic [7:0] seg_raw;
    logic [DIGITS-1:0] en_raw;
`ifdef HEX_SCAN_LZB_EN
    logic upper_zero;
`endif
    nib    = '0;
    dp_bit = 1'b0;
    en_raw = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        nib       = disp_val_q[4*i +: 4];
        dp_bit    = disp_dp_q[i];
        en_raw[i] = 1'b1;
      end
    end
    seg_raw = {dp_bit, hex_to_seg(nib)};
`ifdef HEX_SCAN_LZB_EN
    upper_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if ((IW'(i) >= idx_q) && (disp_val_q[4*i +: 4] != 4'h0)) begin
        upper_zero = 1'b0;
      end
    end
    if ((idx_q != '0) && upper_zero) begin
      seg_raw[6:0] = 7'h00;
    end
`endif
    if (in_blank) begin
      en_raw = '0;
    end
    seg_d = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
    en_d  = (EN_ACTIVE_LOW != 0) ? ~en_raw : en_raw;
  end

  // State and output registers; reset clears contents and idles outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q     <= '0;
      idx_q       <= '0;
      disp_val_q  <= '0;
      disp_dp_q   <= '0;
      pend_val_q  <= '0;
      pend_dp_q   <= '0;
      pend_full_q <= 1'b0;
      ready_q     <= 1'b1;
      fs_q        <= 1'b0;
      seg_q       <= SEG_OFF;
      en_q        <= EN_OFF;
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      disp_val_q  <= disp_val_d;
      disp_dp_q   <= disp_dp_d;
      pend_val_q  <= pend_val_d;
      pend_dp_q   <= pend_dp_d;
      pend_full_q <= pend_full_d;
      ready_q     <= ready_d;
      fs_q        <= fs_d;
      seg_q       <= seg_d;
      en_q        <= en_d;
    end
  end

  assign in_ready        = ready_q;
  assign segments        = seg_q;
  assign segments_enable = en_q;
  assign frame_start     = fs_q;

endmodule

// File: tb/tb_hex_scan.sv
// tb_hex_scan: self-checking bench for hex_scan (DIGITS=3, TPD=4).
// A reference model built from frame arithmetic predicts every output
// cycle; a second instance with BLANK_TICKS=1 checks the blanking window.
module tb_hex_scan;

  localparam int D   = 3;
  localparam int TPD = 4;
  localparam int FR  = TPD * D;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inValid = 1'b0;
  logic [11:0] inValue = '0;
  logic [2:0]  inDp = '0;
  logic        inReady, inReadyB;
  logic [7:0]  segments, segmentsB;
  logic [2:0]  segEnable, segEnableB;
  logic        frameStart, frameStartB;

  int numChecks = 0;
  int numFails  = 0;

  // Reference model state: k counts non-reset edges since reset.
  int          k = 0;
  logic [11:0] mDisp = '0;
  logic [2:0]  mDispDp = '0;
  logic [11:0] mPend = '0;
  logic [2:0]  mPendDp = '0;
  bit          mPendFull = 1'b0;
  bit          mReady = 1'b1;

  logic [6:0] decTable [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  hex_scan #(.DIGITS(3), .SYS_CLK_FREQ(1200), .REFRESH_RATE(100), .BLANK_TICKS(0),
             .SEG_ACTIVE_LOW(1), .EN_ACTIVE_LOW(1)) dut (
    .clk(clk), .reset(reset), .in_value(inValue), .in_dp(inDp), .in_valid(inValid),
    .in_ready(inReady), .segments(segments), .segments_enable(segEnable),
    .frame_start(frameStart));

  hex_scan #(.DIGITS(3), .SYS_CLK_FREQ(1200), .REFRESH_RATE(100), .BLANK_TICKS(1),
             .SEG_ACTIVE_LOW(1), .EN_ACTIVE_LOW(1)) dutBlank (
    .clk(clk), .reset(reset), .in_value(inValue), .in_dp(inDp), .in_valid(inValid),
    .in_ready(inReadyB), .segments(segmentsB), .segments_enable(segEnableB),
    .frame_start(frameStartB));

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Counts one comparison and reports it when observed differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    numChecks++;
    if (obs !== exp) begin
      numFails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected (active-low) segment byte for digit idx of value v.
  function automatic logic [7:0] expSegFor(input logic [11:0] v, input logic [2:0] dp, input int idx);
    logic [11:0] upper;
    logic [7:0]  raw;
    upper = v >> (4 * idx);
    raw   = {dp[idx], decTable[upper[3:0]]};
`ifdef HEX_SCAN_LZB_EN
    if (idx > 0 && upper == 12'h000) raw[6:0] = 7'h00;
`endif
    return ~raw;
  endfunction

  // Drives one cycle of inputs, advances the model over the edge and checks outputs.
  task automatic applyStimulus(input bit r, input bit v, input logic [11:0] val, input logic [2:0] dp);
    logic [7:0] expSeg;
    logic [2:0] expEn, expEnB;
    bit         expFs;
    int         presc, idx;
    reset   = r;
    inValid = v;
    inValue = val;
    inDp    = dp;
    if (r) begin
      expSeg = 8'hFF;
      expEn  = 3'b111;
      expEnB = 3'b111;
      expFs  = 1'b0;
    end else begin
      presc  = k % TPD;
      idx    = (k / TPD) % D;
      expSeg = expSegFor(mDisp, mDispDp, idx);
      expEn  = ~(3'(1 << idx));
      expEnB = (presc < 1) ? 3'b111 : expEn;
      expFs  = ((k + 1) % FR == 0);
    end
    @(posedge clk);
    if (r) begin
      k = 0; mDisp = '0; mDispDp = '0; mPendFull = 1'b0; mReady = 1'b1;
    end else begin
      k++;
      if ((k % FR == 0) && mPendFull) begin
        mDisp = mPend; mDispDp = mPendDp; mPendFull = 1'b0;
      end else if (v && mReady) begin
        mPend = val; mPendDp = dp; mPendFull = 1'b1;
      end
      mReady = !mPendFull;
    end
    #1;
    checkOutput("segments", 32'(segments), 32'(expSeg));
    checkOutput("enable", 32'(segEnable), 32'(expEn));
    checkOutput("frame_start", 32'(frameStart), 32'(expFs));
    checkOutput("in_ready", 32'(inReady), 32'(mReady));
    checkOutput("segmentsBlank", 32'(segmentsB), 32'(expSeg));
    checkOutput("enableBlank", 32'(segEnableB), 32'(expEnB));
    checkOutput("frameStartBlank", 32'(frameStartB), 32'(expFs));
    checkOutput("inReadyBlank", 32'(inReadyB), 32'(mReady));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 12'($urandom), 3'($urandom));
  endtask

  // Holds an offer until the handshake completes, bounded to a few frames.
  task automatic offerValue(input logic [11:0] val, input logic [2:0] dp);
    bit accepted;
    accepted = 1'b0;
    for (int i = 0; i < 4 * FR && !accepted; i++) begin
      accepted = mReady;
      applyStimulus(1'b0, 1'b1, val, dp);
    end
    if (!accepted) checkOutput("offerTimeout", 32'd0, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 12'h000, 3'b000);
    checkOutput("resetSegments", 32'(segments), 32'h0000_00FF);
    checkOutput("resetEnable", 32'(segEnable), 32'h0000_0007);
    checkOutput("resetReady", 32'(inReady), 32'h0000_0001);
    idle(2 * FR + 3);
    idle(5);
    offerValue(12'hA5F, 3'b000);
    idle(3 * FR);
    offerValue(12'h123, 3'b000);
    offerValue(12'h456, 3'b000);
    idle(3 * FR);
    offerValue(12'h008, 3'b010);
    idle(2 * FR);
    offerValue(12'h777, 3'b101);
    offerValue(12'h999, 3'b011);
    idle(2);
    applyStimulus(1'b1, 1'b0, 12'h000, 3'b000);
    checkOutput("midResetEnable", 32'(segEnable), 32'h0000_0007);
    checkOutput("midResetReady", 32'(inReady), 32'h0000_0001);
    idle(2 * FR);
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 499) == 0), ($urandom_range(0, 3) == 0),
                    12'($urandom), 3'($urandom));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
